// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   Host-to-device PS/2 transmitter. Sends one command byte to the keyboard over
//   the shared open-drain clock/data lines. It first inhibits the bus, then
//   requests to send, clocks the bits out on the device's falling edges, and
//   finally checks for the device's acknowledge.
//
// Ports
//   clock        in   system clock
//   resetn       in   asynchronous active-low reset (releases both lines at once)
//   tx_data      in   [7:0] byte to send
//   tx_valid     in   send request; accepted when tx_valid && tx_ready
//   tx_ready     out  high only while idle
//   tx_busy      out  high whenever a send is in progress
//   tx_done      out  1-cycle pulse, device acknowledged the byte
//   tx_error     out  1-cycle pulse, timeout or missing acknowledge
//   ps2_clk_in   in   raw ps2 clock line level (asynchronous)
//   ps2_data_in  in   raw ps2 data line level (asynchronous)
//   ps2_clk_oe   out  1 = pull ps2 clock low, 0 = release
//   ps2_data_oe  out  1 = pull ps2 data low, 0 = release
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int START_TIMEOUT  = 750000,
  parameter int BIT_TIMEOUT    = 100000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INHIBIT  = 3'd1,
    ST_REQ      = 3'd2,
    ST_DATA     = 3'd3,
    ST_PARITY   = 3'd4,
    ST_STOP     = 3'd5,
    ST_WAIT_REL = 3'd6,
    ST_ERR      = 3'd7
  } state_t;

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FW-1:0] FLT_LAST   = FW'(FILTER_LEN - 1);
  localparam logic [31:0]   INH_LAST   = 32'(INHIBIT_CYCLES);
  localparam logic [31:0]   INH_DATA   = 32'(INHIBIT_CYCLES - 1);
  localparam logic [31:0]   START_LAST = 32'(START_TIMEOUT - 1);
  localparam logic [31:0]   BIT_LAST   = 32'(BIT_TIMEOUT - 1);

  // Odd parity bit: makes the total number of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  state_t        state_r, state_nxt_s;
  logic [1:0]    clk_sync_r, data_sync_r;
  logic          clk_filt_r, fall_r;
  logic [FW-1:0] flt_cnt_r;
  logic [7:0]    shift_r;
  logic          parity_r;
  logic [3:0]    bitcnt_r;
  logic [31:0]   tmr_r;
  logic          tx_ready_r, tx_busy_r, tx_done_r, tx_error_r, clk_oe_r, data_oe_r;
  logic          ready_nxt_s, busy_nxt_s, done_nxt_s, error_nxt_s, clk_oe_nxt_s, data_oe_nxt_s;

  assign tx_ready    = tx_ready_r;
  assign tx_busy     = tx_busy_r;
  assign tx_done     = tx_done_r;
  assign tx_error    = tx_error_r;
  assign ps2_clk_oe  = clk_oe_r;
  assign ps2_data_oe = data_oe_r;

  // Line synchronizers and ps2 clock glitch filter with a one-cycle fall strobe.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
      clk_filt_r  <= 1'b1;
      flt_cnt_r   <= {FW{1'b0}};
      fall_r      <= 1'b0;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], ps2_clk_in};
      data_sync_r <= {data_sync_r[0], ps2_data_in};
      if (clk_sync_r[1] == clk_filt_r) begin
        // Any sample agreeing with the filtered level restarts the run.
        flt_cnt_r <= {FW{1'b0}};
        fall_r    <= 1'b0;
      end else if (flt_cnt_r == FLT_LAST) begin
        clk_filt_r <= clk_sync_r[1];
        flt_cnt_r  <= {FW{1'b0}};
        fall_r     <= ~clk_sync_r[1];
      end else begin
        flt_cnt_r <= flt_cnt_r + FW'(1);
        fall_r    <= 1'b0;
      end
    end
  end

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; every waiting state falls back to ERR when its timer expires.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (tx_valid && tx_ready_r) state_nxt_s = ST_INHIBIT;
        else                        state_nxt_s = ST_IDLE;
      end
      ST_INHIBIT: begin
        if (tmr_r == INH_LAST) state_nxt_s = ST_REQ;
        else                   state_nxt_s = ST_INHIBIT;
      end
      ST_REQ: begin
        if (fall_r)                   state_nxt_s = ST_DATA;
        else if (tmr_r == START_LAST) state_nxt_s = ST_ERR;
        else                          state_nxt_s = ST_REQ;
      end
      ST_DATA: begin
        if (fall_r) begin
          if (bitcnt_r == 4'd8) state_nxt_s = ST_PARITY;
          else                  state_nxt_s = ST_DATA;
        end else if (tmr_r == BIT_LAST) begin
          state_nxt_s = ST_ERR;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (fall_r)                 state_nxt_s = ST_STOP;
        else if (tmr_r == BIT_LAST) state_nxt_s = ST_ERR;
        else                        state_nxt_s = ST_PARITY;
      end
      ST_STOP: begin
        // Device acknowledges by holding data low across the final fall.
        if (fall_r) begin
          if (data_sync_r[1]) state_nxt_s = ST_ERR;
          else                state_nxt_s = ST_WAIT_REL;
        end else if (tmr_r == BIT_LAST) begin
          state_nxt_s = ST_ERR;
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      ST_WAIT_REL: begin
        if (clk_filt_r && data_sync_r[1]) state_nxt_s = ST_IDLE;
        else if (tmr_r == BIT_LAST)       state_nxt_s = ST_ERR;
        else                              state_nxt_s = ST_WAIT_REL;
      end
      ST_ERR:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode; values are computed for the coming cycle and registered below.
  always_comb begin
    ready_nxt_s   = (state_nxt_s == ST_IDLE);
    busy_nxt_s    = (state_nxt_s != ST_IDLE);
    done_nxt_s    = (state_r == ST_WAIT_REL) && (state_nxt_s == ST_IDLE);
    error_nxt_s   = (state_nxt_s == ST_ERR);
    clk_oe_nxt_s  = (state_nxt_s == ST_INHIBIT);
    data_oe_nxt_s = 1'b0;
    if ((state_nxt_s == ST_IDLE) || (state_nxt_s == ST_ERR)) begin
      data_oe_nxt_s = 1'b0;
    end else begin
      // Data only ever changes on a filtered fall, so the device sees it stable at its rise.
      case (state_r)
        ST_IDLE:    data_oe_nxt_s = 1'b0;
        ST_INHIBIT: data_oe_nxt_s = (tmr_r >= INH_DATA);
        ST_REQ:     data_oe_nxt_s = fall_r ? ~shift_r[0] : data_oe_r;
        ST_DATA: begin
          if (fall_r) begin
            if (bitcnt_r == 4'd8) data_oe_nxt_s = ~parity_r;
            else                  data_oe_nxt_s = ~shift_r[bitcnt_r[2:0]];
          end else begin
            data_oe_nxt_s = data_oe_r;
          end
        end
        ST_PARITY:  data_oe_nxt_s = fall_r ? 1'b0 : data_oe_r;
        default:    data_oe_nxt_s = 1'b0;
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tx_ready_r <= 1'b0;
      tx_busy_r  <= 1'b0;
      tx_done_r  <= 1'b0;
      tx_error_r <= 1'b0;
      clk_oe_r   <= 1'b0;
      data_oe_r  <= 1'b0;
    end else begin
      tx_ready_r <= ready_nxt_s;
      tx_busy_r  <= busy_nxt_s;
      tx_done_r  <= done_nxt_s;
      tx_error_r <= error_nxt_s;
      clk_oe_r   <= clk_oe_nxt_s;
      data_oe_r  <= data_oe_nxt_s;
    end
  end

  // Byte/parity capture, bit counter and the shared phase/timeout timer.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shift_r  <= 8'h00;
      parity_r <= 1'b0;
      bitcnt_r <= 4'd0;
      tmr_r    <= 32'd0;
    end else begin
      if ((state_r == ST_IDLE) && (state_nxt_s == ST_INHIBIT)) begin
        shift_r  <= tx_data;
        parity_r <= odd_parity(tx_data);
        bitcnt_r <= 4'd0;
      end else if ((state_r == ST_REQ) && fall_r) begin
        bitcnt_r <= 4'd1;
      end else if ((state_r == ST_DATA) && fall_r && (bitcnt_r != 4'd8)) begin
        bitcnt_r <= bitcnt_r + 4'd1;
      end else begin
        bitcnt_r <= bitcnt_r;
      end
      // Falls seen during INHIBIT are our own clock pull, so they must not restart the timer.
      if ((state_r == ST_IDLE) || (state_nxt_s != state_r) ||
          (fall_r && (state_r != ST_INHIBIT))) begin
        tmr_r <= 32'd0;
      end else begin
        tmr_r <= tmr_r + 32'd1;
      end
    end
  end

endmodule
